// File: rtl/vc_pmem_arbiter.sv
// vc_pmem_arbiter: shares the single physical-memory port between L2 line
// fills and victim-cache dirty-line writebacks.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   l2_read/l2_addr              fill request, held until l2_resp
//   l2_rdata/l2_resp             fill data and one-cycle completion pulse
//   vc_write/vc_addr/vc_wdata    writeback request, held until vc_resp
//   vc_resp                      one-cycle writeback completion pulse
//   l2_pmem_busy                 arbiter busy or fill pending
//   pmem_read/pmem_write         pmem strobes, held until pmem_resp
//   pmem_address/pmem_wdata      registered line address / writeback data
//   pmem_rdata/pmem_resp         pmem read data and completion pulse
//
// Reads win arbitration unless a waiting writeback has already been passed
// over STARVE_MAX times. Every transaction ends with a one-cycle BREAK bubble
// so requesters can drop their request lines before the next grant.
//
// Optional feature: define PMEM_ARB_FWD_EN to service a fill whose line
// address matches a pending writeback directly from the writeback data,
// without a pmem read.
module vc_pmem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned LINE_W     = 256,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l2_read,
  input  logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_rdata,
  output logic              l2_resp,
  input  logic              vc_write,
  input  logic [ADDR_W-1:0] vc_addr,
  input  logic [LINE_W-1:0] vc_wdata,
  output logic              vc_resp,
  output logic              l2_pmem_busy,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int unsigned OFF_W = $clog2(LINE_W / 8);
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFF_W) - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, RD, WR, BREAK} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;
  logic [LINE_W-1:0] rdata_q;
  logic              grant_rd, grant_wr;
  logic              starve_hit;

`ifdef PMEM_ARB_FWD_EN
  logic fwd_hit, fwd_grant, fwd_q;

  // Writebacks always finish before the arbiter is back in IDLE, so only a
  // pending writeback request can alias an incoming fill.
  assign fwd_hit = vc_write && ((l2_addr & LINE_MASK) == (vc_addr & LINE_MASK));
`endif

  assign starve_hit   = vc_write && (starve_cnt == CNT_MAX);
  assign l2_pmem_busy = (state != IDLE) | l2_read;

  // Fill data comes straight from pmem in the completion cycle, otherwise
  // from the capture register.
  assign l2_rdata = (state == RD) ? pmem_rdata : rdata_q;

  // Next-state, grant and response decode.
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    grant_rd       = 1'b0;
    grant_wr       = 1'b0;
    l2_resp        = 1'b0;
    vc_resp        = 1'b0;
`ifdef PMEM_ARB_FWD_EN
    fwd_grant      = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (!vc_write) starve_cnt_nxt = '0;
        if (l2_read && !starve_hit) begin
          // starve_hit is false here, so a waiting writeback is below the cap.
          if (vc_write) starve_cnt_nxt = starve_cnt + CNT_W'(1);
`ifdef PMEM_ARB_FWD_EN
          if (fwd_hit) begin
            fwd_grant = 1'b1;
            state_nxt = BREAK;
          end else begin
            grant_rd  = 1'b1;
            state_nxt = RD;
          end
`else
          grant_rd  = 1'b1;
          state_nxt = RD;
`endif
        end else if (vc_write) begin
          grant_wr       = 1'b1;
          starve_cnt_nxt = '0;
          state_nxt      = WR;
        end
      end
      RD: begin
        if (pmem_resp) begin
          l2_resp   = 1'b1;
          state_nxt = BREAK;
        end
      end
      WR: begin
        if (pmem_resp) begin
          vc_resp   = 1'b1;
          state_nxt = BREAK;
        end
      end
      BREAK: begin
`ifdef PMEM_ARB_FWD_EN
        // A forwarded fill responds in its first BREAK cycle and then takes
        // one more BREAK cycle as the bubble.
        if (fwd_q) l2_resp = 1'b1;
        else       state_nxt = IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, strobes and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      rdata_q      <= '0;
`ifdef PMEM_ARB_FWD_EN
      fwd_q        <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      pmem_read  <= (state_nxt == RD);
      pmem_write <= (state_nxt == WR);
      if (grant_rd) pmem_address <= l2_addr & LINE_MASK;
      if (grant_wr) begin
        pmem_address <= vc_addr & LINE_MASK;
        pmem_wdata   <= vc_wdata;
      end
      if (state == RD && pmem_resp) rdata_q <= pmem_rdata;
`ifdef PMEM_ARB_FWD_EN
      fwd_q <= fwd_grant;
      if (fwd_grant) rdata_q <= vc_wdata;
`endif
    end
  end

endmodule

// File: tb/tb_vc_pmem_arbiter.sv
// tb_vc_pmem_arbiter: directed bench for vc_pmem_arbiter. A cycle table
// covers a plain fill, a request dropped before grant, and a read/write
// collision; hand-written sequences cover starvation, reset during a
// writeback and fill/writeback address aliasing (with or without
// PMEM_ARB_FWD_EN).
module tb_vc_pmem_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              l2_read;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;
  logic              vc_write;
  logic [ADDR_W-1:0] vc_addr;
  logic [LINE_W-1:0] vc_wdata;
  logic              vc_resp;
  logic              l2_pmem_busy;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  vc_pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .l2_read(l2_read), .l2_addr(l2_addr), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .vc_write(vc_write), .vc_addr(vc_addr), .vc_wdata(vc_wdata), .vc_resp(vc_resp),
    .l2_pmem_busy(l2_pmem_busy),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  localparam logic [LINE_W-1:0] RD_DATA = {32{8'hA5}};
  localparam logic [LINE_W-1:0] WB_DATA = {8{32'hDEADBEEF}};
  localparam logic [LINE_W-1:0] FW_DATA = {16{16'h5A3C}};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic              l2r;
    logic [ADDR_W-1:0] l2a;
    logic              vcw;
    logic [ADDR_W-1:0] vca;
    logic              presp;
    logic              e_busy;
    logic              e_rd;
    logic              e_wr;
    logic [ADDR_W-1:0] e_addr;
    logic              e_l2resp;
    logic              e_vcresp;
  } vec_t;

  function automatic vec_t mk(input logic l2r, input logic [15:0] l2a, input logic vcw,
                              input logic [15:0] vca, input logic presp, input logic e_busy,
                              input logic e_rd, input logic e_wr, input logic [15:0] e_addr,
                              input logic e_l2resp, input logic e_vcresp);
    vec_t v;
    v.l2r = l2r; v.l2a = l2a; v.vcw = vcw; v.vca = vca; v.presp = presp;
    v.e_busy = e_busy; v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr;
    v.e_l2resp = e_l2resp; v.e_vcresp = e_vcresp;
    return v;
  endfunction

  vec_t vecs[15];

  // Starvation: both requests held, pmem answers each strobe at once.
  task automatic starve_round(input int round);
    int  reads = 0;
    bit  prev_rd = 1'b0;
    bit  got_wr = 1'b0;
    for (int c = 0; c < 100 && !got_wr; c++) begin
      @(negedge clk);
      pmem_resp = pmem_read | pmem_write;
      #1;
      if (pmem_read && !prev_rd) reads++;
      prev_rd = pmem_read;
      if (pmem_write) begin
        got_wr = 1'b1;
        chk($sformatf("starve%0d_reads_before_wr", round), LINE_W'(reads), LINE_W'(4));
        chk($sformatf("starve%0d_wr_addr", round), LINE_W'(pmem_address), LINE_W'(16'h0080));
        chk($sformatf("starve%0d_vc_resp", round), LINE_W'(vc_resp), LINE_W'(1));
      end
    end
    chk($sformatf("starve%0d_write_granted", round), LINE_W'(got_wr), LINE_W'(1));
    @(posedge clk);
    #1 pmem_resp = 1'b0;
  endtask

  initial begin
    bit saw_rd, got_l2, got_vc, drop_l2, drop_vc;
    rst = 1'b1; l2_read = 1'b0; l2_addr = '0; vc_write = 1'b0; vc_addr = '0;
    vc_wdata = WB_DATA; pmem_rdata = RD_DATA; pmem_resp = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pmem_read", LINE_W'(pmem_read), '0);
    chk("rst_pmem_write", LINE_W'(pmem_write), '0);
    chk("rst_pmem_address", LINE_W'(pmem_address), '0);
    chk("rst_pmem_wdata", pmem_wdata, '0);
    chk("rst_l2_rdata", l2_rdata, '0);
    chk("rst_l2_resp", LINE_W'(l2_resp), '0);
    chk("rst_vc_resp", LINE_W'(vc_resp), '0);
    chk("rst_busy", LINE_W'(l2_pmem_busy), '0);
    rst = 1'b0;

    //               l2r l2a      vcw vca      prsp busy rd wr addr     l2r vcr
    vecs[0]  = mk(1, 16'h1240, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0);
    vecs[1]  = mk(1, 16'h1240, 1, 16'h0F00, 0, 1, 1, 0, 16'h1240, 0, 0);
    vecs[2]  = mk(1, 16'h1240, 1, 16'h0F00, 0, 1, 1, 0, 16'h1240, 0, 0);
    vecs[3]  = mk(1, 16'h1240, 0, 16'h0000, 1, 1, 1, 0, 16'h1240, 1, 0);
    vecs[4]  = mk(0, 16'h0000, 0, 16'h0000, 0, 1, 0, 0, 16'h1240, 0, 0);
    vecs[5]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h1240, 0, 0);
    vecs[6]  = mk(1, 16'h0020, 1, 16'h0040, 0, 1, 0, 0, 16'h1240, 0, 0);
    vecs[7]  = mk(0, 16'h0020, 1, 16'h0040, 0, 1, 1, 0, 16'h0020, 0, 0);
    vecs[8]  = mk(0, 16'h0020, 1, 16'h0040, 1, 1, 1, 0, 16'h0020, 1, 0);
    vecs[9]  = mk(0, 16'h0000, 1, 16'h0040, 0, 1, 0, 0, 16'h0020, 0, 0);
    vecs[10] = mk(0, 16'h0000, 1, 16'h0040, 0, 0, 0, 0, 16'h0020, 0, 0);
    vecs[11] = mk(0, 16'h0000, 1, 16'h0040, 0, 1, 0, 1, 16'h0040, 0, 0);
    vecs[12] = mk(0, 16'h0000, 1, 16'h0040, 1, 1, 0, 1, 16'h0040, 0, 1);
    vecs[13] = mk(0, 16'h0000, 0, 16'h0000, 0, 1, 0, 0, 16'h0040, 0, 0);
    vecs[14] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0040, 0, 0);

    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      l2_read = vecs[i].l2r; l2_addr = vecs[i].l2a;
      vc_write = vecs[i].vcw; vc_addr = vecs[i].vca; pmem_resp = vecs[i].presp;
      @(negedge clk);
      chk($sformatf("v%0d_busy", i), LINE_W'(l2_pmem_busy), LINE_W'(vecs[i].e_busy));
      chk($sformatf("v%0d_pmem_read", i), LINE_W'(pmem_read), LINE_W'(vecs[i].e_rd));
      chk($sformatf("v%0d_pmem_write", i), LINE_W'(pmem_write), LINE_W'(vecs[i].e_wr));
      chk($sformatf("v%0d_pmem_address", i), LINE_W'(pmem_address), LINE_W'(vecs[i].e_addr));
      chk($sformatf("v%0d_l2_resp", i), LINE_W'(l2_resp), LINE_W'(vecs[i].e_l2resp));
      chk($sformatf("v%0d_vc_resp", i), LINE_W'(vc_resp), LINE_W'(vecs[i].e_vcresp));
      if (vecs[i].e_l2resp) chk($sformatf("v%0d_l2_rdata", i), l2_rdata, RD_DATA);
      if (vecs[i].e_wr) chk($sformatf("v%0d_pmem_wdata", i), pmem_wdata, WB_DATA);
    end

    // Starvation: two rounds show the counter restarts from zero.
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    l2_read = 1'b1; l2_addr = 16'h0100; vc_write = 1'b1; vc_addr = 16'h0080;
    starve_round(1);
    starve_round(2);
    l2_read = 1'b0; vc_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("starve_idle_busy", LINE_W'(l2_pmem_busy), '0);

    // Reset during a writeback.
    vc_write = 1'b1; vc_addr = 16'h0A00; vc_wdata = FW_DATA;
    saw_rd = 1'b0;
    for (int c = 0; c < 10 && !saw_rd; c++) begin
      @(negedge clk);
      if (pmem_write) saw_rd = 1'b1;
    end
    chk("rstwr_write_seen", LINE_W'(saw_rd), LINE_W'(1));
    rst = 1'b1; vc_write = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstwr_pmem_write", LINE_W'(pmem_write), '0);
    chk("rstwr_pmem_read", LINE_W'(pmem_read), '0);
    chk("rstwr_vc_resp", LINE_W'(vc_resp), '0);
    chk("rstwr_busy", LINE_W'(l2_pmem_busy), '0);
    chk("rstwr_pmem_address", LINE_W'(pmem_address), '0);
    chk("rstwr_pmem_wdata", pmem_wdata, '0);
    chk("rstwr_l2_rdata", l2_rdata, '0);
    got_vc = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      pmem_resp = 1'b1;
      #1;
      if (vc_resp || pmem_write) got_vc = 1'b1;
    end
    chk("rstwr_abandoned", LINE_W'(got_vc), '0);
    @(posedge clk);
    #1 pmem_resp = 1'b0;

    // Fill aliasing a pending writeback line.
    vc_write = 1'b1; vc_addr = 16'h3000; vc_wdata = FW_DATA;
    l2_read = 1'b1; l2_addr = 16'h301C;
    saw_rd = 1'b0; got_l2 = 1'b0; got_vc = 1'b0;
    for (int c = 0; c < 40 && !got_vc; c++) begin
      drop_l2 = 1'b0; drop_vc = 1'b0;
      @(negedge clk);
      pmem_resp = pmem_read | pmem_write;
      #1;
      if (pmem_read) begin
        saw_rd = 1'b1;
        chk("alias_rd_addr", LINE_W'(pmem_address), LINE_W'(16'h3000));
      end
      if (l2_resp) begin
        got_l2 = 1'b1; drop_l2 = 1'b1;
`ifdef PMEM_ARB_FWD_EN
        chk("alias_l2_rdata", l2_rdata, FW_DATA);
`else
        chk("alias_l2_rdata", l2_rdata, RD_DATA);
`endif
      end
      if (vc_resp) begin
        got_vc = 1'b1; drop_vc = 1'b1;
        chk("alias_wb_addr", LINE_W'(pmem_address), LINE_W'(16'h3000));
        chk("alias_wb_data", pmem_wdata, FW_DATA);
        chk("alias_wb_after_fill", LINE_W'(got_l2), LINE_W'(1));
      end
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (drop_l2) l2_read = 1'b0;
      if (drop_vc) vc_write = 1'b0;
    end
    chk("alias_l2_resp_seen", LINE_W'(got_l2), LINE_W'(1));
    chk("alias_vc_resp_seen", LINE_W'(got_vc), LINE_W'(1));
`ifdef PMEM_ARB_FWD_EN
    chk("alias_pmem_read_issued", LINE_W'(saw_rd), LINE_W'(0));
`else
    chk("alias_pmem_read_issued", LINE_W'(saw_rd), LINE_W'(1));
`endif
    l2_read = 1'b0; vc_write = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
